// File: rtl/countdown_timer_gen_if.sv
// Command/status bundle for one countdown timer channel.
// Master issues commands, slave (the timer) reports time and flags.
interface countdown_timer_gen_if #(
  parameter int W = 7
);

  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         clear;
  logic         auto_reload;
  logic [W-1:0] time_out;
  logic         running;
  logic         paused;
  logic         done;
  logic         expired;
  logic         tick;
  logic [11:0]  bcd_out;

  modport master (
    output load,
    output load_val,
    output start,
    output pause,
    output clear,
    output auto_reload,
    input  time_out,
    input  running,
    input  paused,
    input  done,
    input  expired,
    input  tick,
    input  bcd_out
  );

  modport slave (
    input  load,
    input  load_val,
    input  start,
    input  pause,
    input  clear,
    input  auto_reload,
    output time_out,
    output running,
    output paused,
    output done,
    output expired,
    output tick,
    output bcd_out
  );

endinterface

// File: rtl/countdown_timer_gen.sv
// Countdown timer: prescaled tick, pause/resume, auto-reload.
// Define TIMER_BCD_EN for a registered 3-digit BCD copy of time_out.
module countdown_timer_gen #(
  parameter int W           = 7,
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEFAULT_VAL = 60
) (
  input  logic                 clk,
  input  logic                 rst_n,
  countdown_timer_gen_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [W-1:0]  DVAL = W'(DEFAULT_VAL);
  localparam logic [W-1:0]  ONE  = W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_n;
  logic [W-1:0]  t_q, t_n;
  logic [W-1:0]  rl_q, rl_n;
  logic [PW-1:0] presc, presc_n;
  logic          exp_q, exp_n;
  logic          tick_w;
  logic          start_ok;

  assign tick_w = (state == S_RUN) && (presc == PMAX);

  // A start only counts when it has somewhere to go
  always_comb begin
    start_ok = 1'b0;
    unique case (state)
      S_IDLE:  start_ok = bus.start && (t_q != '0);
      S_PAUSE: start_ok = bus.start;
      S_DONE:  start_ok = bus.start && (rl_q != '0);
      default: start_ok = 1'b0;
    endcase
  end

  // Next-state: commands first, a tick only applies when no command acts
  always_comb begin
    state_n = state;
    t_n     = t_q;
    rl_n    = rl_q;
    presc_n = presc;
    exp_n   = 1'b0;
    if (state == S_RUN) begin
      presc_n = tick_w ? '0 : presc + PW'(1);
    end
    if (bus.clear) begin
      t_n     = rl_q;
      presc_n = '0;
      state_n = S_IDLE;
    end else if (bus.load) begin
      t_n     = bus.load_val;
      rl_n    = bus.load_val;
      presc_n = '0;
      state_n = S_IDLE;
    end else if (start_ok) begin
      state_n = S_RUN;
      unique case (state)
        S_IDLE: presc_n = '0;
        S_DONE: begin
          t_n     = rl_q;
          presc_n = '0;
        end
        default: presc_n = presc;
      endcase
    end else if (bus.pause && state == S_RUN) begin
      state_n = S_PAUSE;
    end else if (tick_w) begin
      if (t_q > ONE) begin
        t_n = t_q - ONE;
      end else if (t_q == ONE) begin
        exp_n = 1'b1;
        if (bus.auto_reload && rl_q != '0) begin
          t_n = rl_q;
        end else begin
          t_n     = '0;
          state_n = S_DONE;
        end
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      t_q   <= DVAL;
      rl_q  <= DVAL;
      presc <= '0;
      exp_q <= 1'b0;
    end else begin
      state <= state_n;
      t_q   <= t_n;
      rl_q  <= rl_n;
      presc <= presc_n;
      exp_q <= exp_n;
    end
  end

  assign bus.time_out = t_q;
  assign bus.running  = (state == S_RUN);
  assign bus.paused   = (state == S_PAUSE);
  assign bus.done     = (state == S_DONE);
  assign bus.expired  = exp_q;
  assign bus.tick     = tick_w;

`ifdef TIMER_BCD_EN
  logic [W+11:0] sh;
  logic [11:0]   bcd_n;
  logic [11:0]   bcd_q;
  logic          sat;

  assign sat = {12'd0, t_q} > (W+12)'(999);

  // Shift-and-add-3 binary to BCD, unrolled
  always_comb begin
    sh = '0;
    sh[W-1:0] = t_q;
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sh[W+4*d +: 4] > 4'd4) begin
          sh[W+4*d +: 4] = sh[W+4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    bcd_n = sat ? 12'h999 : sh[W +: 12];
  end

  // BCD output lags time_out by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_n;
    end
  end

  assign bus.bcd_out = bcd_q;
`else
  assign bus.bcd_out = 12'h000;
`endif

endmodule

// File: tb/tb_countdown_timer_gen.sv
// Bench for countdown_timer_gen: directed cases plus random
// command streams against a cycle-count reference model.
module tb_countdown_timer_gen;

  localparam int W    = 7;
  localparam int CHZ  = 100;
  localparam int THZ  = 10;
  localparam int DEFV = 60;
  localparam int DIV  = CHZ / THZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  countdown_timer_gen_if #(.W(W)) bus ();

  countdown_timer_gen #(
    .W(W),
    .CLK_HZ(CHZ),
    .TICK_HZ(THZ),
    .DEFAULT_VAL(DEFV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;

  int   n_vec = 0;
  int   n_err = 0;
  mst_t m_st;
  int   m_time, m_reload, m_cnt;
  bit   m_exp;
  int   m_bcd;

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(int v);
    int s;
    s = (v > 999) ? 999 : v;
    return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  function automatic bit m_tick();
    return (m_st == M_RUN) && (m_cnt == DIV - 1);
  endfunction

  task automatic m_reset();
    m_st     = M_IDLE;
    m_time   = DEFV;
    m_reload = DEFV;
    m_cnt    = 0;
    m_exp    = 0;
    m_bcd    = 0;
  endtask

  task automatic m_step(bit ld, int lv, bit st, bit ps, bit cl, bit ar);
    bit tk;
    int nb;
    tk    = m_tick();
    nb    = to_bcd(m_time);
    m_exp = 0;
    if (cl) begin
      m_time = m_reload;
      m_cnt  = 0;
      m_st   = M_IDLE;
    end else if (ld) begin
      m_time   = lv;
      m_reload = lv;
      m_cnt    = 0;
      m_st     = M_IDLE;
    end else if (st && m_st == M_IDLE && m_time != 0) begin
      m_cnt = 0;
      m_st  = M_RUN;
    end else if (st && m_st == M_PAUSE) begin
      m_st = M_RUN;
    end else if (st && m_st == M_DONE && m_reload != 0) begin
      m_time = m_reload;
      m_cnt  = 0;
      m_st   = M_RUN;
    end else if (m_st == M_RUN) begin
      m_cnt = (m_cnt + 1) % DIV;
      if (ps) begin
        m_st = M_PAUSE;
      end else if (tk) begin
        if (m_time > 1) begin
          m_time--;
        end else if (m_time == 1) begin
          m_exp = 1;
          if (ar && m_reload != 0) begin
            m_time = m_reload;
          end else begin
            m_time = 0;
            m_st   = M_DONE;
          end
        end
      end
    end
`ifdef TIMER_BCD_EN
    m_bcd = nb;
`else
    m_bcd = 0;
`endif
  endtask

  task automatic check_all();
    chk("time_out", int'(bus.time_out), m_time);
    chk("running", int'(bus.running), int'(m_st == M_RUN));
    chk("paused", int'(bus.paused), int'(m_st == M_PAUSE));
    chk("done", int'(bus.done), int'(m_st == M_DONE));
    chk("expired", int'(bus.expired), int'(m_exp));
    chk("bcd_out", int'(bus.bcd_out), m_bcd);
  endtask

  task automatic drive(bit ld, int lv, bit st, bit ps,
                       bit cl, bit ar);
    bus.load        = ld;
    bus.load_val    = W'(lv);
    bus.start       = st;
    bus.pause       = ps;
    bus.clear       = cl;
    bus.auto_reload = ar;
    chk("tick", int'(bus.tick), int'(m_tick()));
    m_step(ld, lv, st, ps, cl, ar);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(int n, bit ar);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, ar);
  endtask

  int ecnt;
  int r;
  bit ar;

  initial begin
    bus.load        = 0;
    bus.load_val    = '0;
    bus.start       = 0;
    bus.pause       = 0;
    bus.clear       = 0;
    bus.auto_reload = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", int'(bus.time_out), 60);
    chk("rst_flags", int'({bus.running, bus.paused,
        bus.done, bus.expired, bus.tick}), 0);
    chk("rst_bcd", int'(bus.bcd_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_step(0, 0, 0, 0, 0, 0);
    check_all();

    // Expiry of a loaded 3
    drive(1, 3, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(10, 0);
    chk("t2_10", int'(bus.time_out), 2);
    idle(10, 0);
    chk("t2_20", int'(bus.time_out), 1);
    idle(9, 0);
    chk("t2_29exp", int'(bus.expired), 0);
    idle(1, 0);
    chk("t2_30", int'(bus.time_out), 0);
    chk("t2_30exp", int'(bus.expired), 1);
    idle(1, 0);
    chk("t2_exp_end", int'(bus.expired), 0);
    chk("t2_done", int'(bus.done), 1);

    // Pause keeps the partial tick
    drive(1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(14, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("t3_pause", int'(bus.time_out), 4);
    idle(20, 0);
    chk("t3_hold", int'(bus.time_out), 4);
    chk("t3_paused", int'(bus.paused), 1);
    drive(0, 0, 1, 0, 0, 0);
    idle(4, 0);
    chk("t3_r4", int'(bus.time_out), 4);
    idle(1, 0);
    chk("t3_r5", int'(bus.time_out), 3);

    // Auto-reload between 2 and 1
    drive(1, 2, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    ecnt = 0;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      ecnt += int'(bus.expired);
    end
    chk("t4_exp_cnt", ecnt, 2);
    chk("t4_done", int'(bus.done), 0);
    chk("t4_time", int'(bus.time_out), 2);

    // Clear beats load; start with zero time ignored
    drive(1, 7, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(13, 0);
    drive(1, 99, 0, 0, 1, 0);
    chk("t5_clr", int'(bus.time_out), 7);
    chk("t5_idle", int'(bus.running), 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("t5_nostart", int'(bus.running), 0);
    idle(2, 0);
    chk("t5_zero", int'(bus.time_out), 0);

    // BCD view of 59
    drive(1, 59, 0, 0, 0, 0);
    idle(1, 0);
`ifdef TIMER_BCD_EN
    chk("t6_bcd", int'(bus.bcd_out), 'h059);
`else
    chk("t6_bcd", int'(bus.bcd_out), 0);
`endif

    // Async reset mid-count
    drive(1, 9, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle(13, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("t1_time", int'(bus.time_out), 60);
    chk("t1_flags", int'({bus.running, bus.paused,
        bus.done, bus.expired}), 0);
    chk("t1_bcd", int'(bus.bcd_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Random command stream
    ar = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ar = ~ar;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        drive(0, 0, 0, 0, 1, ar);
      end else if (r < 5) begin
        if ($urandom_range(0, 3) == 0)
          drive(1, int'($urandom_range(0, 127)), 0, 0, 0, ar);
        else
          drive(1, int'($urandom_range(0, 4)), 0, 0, 0, ar);
      end else if (r < 13) begin
        drive(0, 0, 1, 0, 0, ar);
      end else if (r < 17) begin
        drive(0, 0, 0, 1, 0, ar);
      end else begin
        drive(0, 0, 0, 0, 0, ar);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
